// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per request as start, 8 data bits LSB first, optional parity, stop bit(s).
// Optional parity bit compiled in by defining UART_TX_PARITY_EN.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       TXD,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [BW-1:0] baud;
  logic [2:0] idx;
  logic [7:0] shift;
  logic bit_end;
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      TXD <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      baud <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_start) begin
          shift <= tx_data;
          state <= START;
          TXD <= 1'b0;
          tx_busy <= 1'b1;
          baud <= '0;
          idx <= '0;
        end
      end else if (!bit_end) begin
        baud <= baud + 1'b1;
      end else begin
        baud <= '0;
        case (state)
          START: begin
            state <= DATA;
            TXD <= shift[0];
            idx <= '0;
          end
          DATA: begin
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TXD <= ^shift ^ PARITY_ODD[0];
`else
              state <= STOP;
              TXD <= 1'b1;
              idx <= '0;
`endif
            end else begin
              idx <= idx + 3'd1;
              TXD <= shift[idx + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            TXD <= 1'b1;
            idx <= '0;
          end
`endif
          STOP: begin
            // idx counts completed stop bits here
            if (idx == 3'(STOP_BITS - 1)) begin
              state <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame checks on a 4-clk/bit and a 1-clk/bit transmitter.
module tb_uart_transmitter;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
  localparam logic [F-1:0] E_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [F-1:0] E_FF = {1'b1, 1'b0, 8'hFF, 1'b0};
  localparam logic [F-1:0] E_3C = {1'b1, 1'b0, 8'h3C, 1'b0};
  localparam logic [F-1:0] E_C3 = {1'b1, 1'b0, 8'hC3, 1'b0};
  localparam logic [F-1:0] E_07E = {1'b1, 1'b1, 8'h07, 1'b0};
  localparam logic [F-1:0] E_07O = {1'b1, 1'b0, 8'h07, 1'b0};
`else
  localparam int F = 10;
  localparam logic [F-1:0] E_A5 = {1'b1, 8'hA5, 1'b0};
  localparam logic [F-1:0] E_FF = {1'b1, 8'hFF, 1'b0};
  localparam logic [F-1:0] E_3C = {1'b1, 8'h3C, 1'b0};
  localparam logic [F-1:0] E_C3 = {1'b1, 8'hC3, 1'b0};
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0] data_a = '0, data_b = '0, data_c = '0;
  logic txd_a, busy_a, done_a, txd_b, busy_b, done_b, txd_c, busy_c, done_c;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .tx_data(data_a), .tx_start(start_a),
    .TXD(txd_a), .tx_busy(busy_a), .tx_done(done_a));
  uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .tx_data(data_b), .tx_start(start_b),
    .TXD(txd_b), .tx_busy(busy_b), .tx_done(done_b));
`ifdef UART_TX_PARITY_EN
  uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .reset(reset), .tx_data(data_c), .tx_start(start_c),
    .TXD(txd_c), .tx_busy(busy_c), .tx_done(done_c));
`else
  assign txd_c = 1'b1;
  assign busy_c = 1'b0;
  assign done_c = 1'b0;
`endif

  task automatic idle_check(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if ({txd_a, busy_a, done_a, txd_b, busy_b, done_b} !== 6'b100100) begin
        errors++;
        $display("FAIL %s cycle %0d: a txd/busy/done=%b%b%b b=%b%b%b want 100", nm, k,
                 txd_a, busy_a, done_a, txd_b, busy_b, done_b);
      end
    end
  endtask

  // Sends d on dut_a (sel=0) or dut_c (sel=1); optional extra request with other data at cycle g.
  task automatic frame(input bit sel, input logic [7:0] d, input logic [F-1:0] e, input int g, input string nm);
    logic t, b, dn;
    @(negedge clk);
    if (sel) begin data_c = d; start_c = 1'b1; end else begin data_a = d; start_a = 1'b1; end
    @(posedge clk);
    #1 start_a = 1'b0; start_c = 1'b0; data_a = ~d; data_c = ~d;
    for (int k = 0; k < F * 4; k++) begin
      @(negedge clk);
      t = sel ? txd_c : txd_a; b = sel ? busy_c : busy_a; dn = sel ? done_c : done_a;
      checks++;
      if ({t, b, dn} !== {e[k / 4], 2'b10}) begin
        errors++;
        $display("FAIL %s cycle %0d: txd/busy/done=%b%b%b want %b10", nm, k, t, b, dn, e[k / 4]);
      end
      if (k == g) begin start_a = !sel; start_c = sel; data_a = 8'h5A; data_c = 8'h5A; end
      if (k == g + 1) begin start_a = 1'b0; start_c = 1'b0; end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      t = sel ? txd_c : txd_a; b = sel ? busy_c : busy_a; dn = sel ? done_c : done_a;
      checks++;
      if ({t, b, dn} !== {2'b10, k == 0}) begin
        errors++;
        $display("FAIL %s end+%0d: txd/busy/done=%b%b%b want 10%b", nm, k, t, b, dn, k == 0);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle_check("reset", 10);
  endtask

  task automatic test_frame;
    frame(1'b0, 8'hA5, E_A5, -1, "frame_a5");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    frame(1'b0, 8'h07, E_07E, -1, "parity_even");
    frame(1'b1, 8'h07, E_07O, -1, "parity_odd");
  endtask
`endif

  task automatic test_back_to_back;
    @(negedge clk);
    data_b = 8'h3C; start_b = 1'b1;
    @(posedge clk);
    #1 data_b = 8'hC3;
    for (int k = 0; k < 2 * F + 2; k++) begin
      @(negedge clk);
      checks++;
      // cycle F is the one idle cycle carrying tx_done; frame 2 is accepted at its end
      if (k < F && {txd_b, busy_b, done_b} !== {E_3C[k], 2'b10} ||
          k == F && {txd_b, busy_b, done_b} !== 3'b101 ||
          k > F && k <= 2 * F && {txd_b, busy_b, done_b} !== {E_C3[k - F - 1], 2'b10} ||
          k == 2 * F + 1 && {txd_b, busy_b, done_b} !== 3'b101) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: txd/busy/done=%b%b%b", k, txd_b, busy_b, done_b);
      end
      if (k == 2 * F + 1) start_b = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({txd_b, busy_b, done_b} !== 3'b100) begin
      errors++;
      $display("FAIL back_to_back stop: txd/busy/done=%b%b%b want 100", txd_b, busy_b, done_b);
    end
  endtask

  task automatic test_ignore_busy;
    frame(1'b0, 8'hA5, E_A5, 13, "ignore_busy");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    data_a = 8'h96; start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({txd_a, busy_a, done_a} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid: txd/busy/done=%b%b%b want 100", txd_a, busy_a, done_a);
    end
    idle_check("reset_mid_after", 6);
    frame(1'b0, 8'hFF, E_FF, -1, "after_reset_ff");
  endtask

  initial begin
    test_reset();
    test_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
